// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyser capture core.
package la_pkg;

    localparam int LA_STATE_W = 3;

    typedef enum logic [LA_STATE_W-1:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        WAIT    = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4
    } la_state_e;

    function automatic int la_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/la_trigger_match.sv
// Pattern/edge trigger compare with its own previous-sample register.
// The first sample after a restart stands in as its own predecessor, so no false edge fires.
module la_trigger_match
    import la_pkg::*;
#(
    parameter int CH_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                _mrst,
    input  logic [CH_WIDTH-1:0] i_data,
    input  logic                i_strobe,
    input  logic                i_restart,
    input  logic [CH_WIDTH-1:0] cfg_mask,
    input  logic [CH_WIDTH-1:0] cfg_value,
    input  logic [CH_WIDTH-1:0] cfg_edge,
    output logic                o_match
);

    logic [CH_WIDTH-1:0] prev_data_q, prev_data_d;
    logic                first_q, first_d;
    logic [CH_WIDTH-1:0] prev_eff;

    always_comb begin
        prev_data_d = prev_data_q;
        first_d     = first_q;
        if (i_restart) begin
            first_d = 1'b1;
        end else if (i_strobe) begin
            prev_data_d = i_data;
            first_d     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            prev_data_q <= '0;
            first_q     <= 1'b0;
        end else begin
            prev_data_q <= prev_data_d;
            first_q     <= first_d;
        end
    end

    assign prev_eff = first_q ? i_data : prev_data_q;
    assign o_match  = (((i_data ^ cfg_value) & cfg_mask) == '0) &&
                      ((cfg_edge & ~prev_eff & i_data) == cfg_edge);

endmodule

// File: rtl/la_capture_core.sv
// Armed circular-buffer capture with pre/post-trigger window and valid/ready readout.
// Define LA_EXT_TRIG_EN to add the i_ext_trig input as an extra trigger source.
module la_capture_core
    import la_pkg::*;
#(
    parameter int  CH_WIDTH = 8,
    parameter int  DEPTH    = 256,
    localparam int AW       = la_aw(DEPTH)
) (
    input  logic                i_clk,
    input  logic                _mrst,
    input  logic [CH_WIDTH-1:0] i_data,
    input  logic                i_sample_en,
    input  logic                i_arm,
    input  logic                i_abort,
`ifdef LA_EXT_TRIG_EN
    input  logic                i_ext_trig,
`endif
    input  logic [CH_WIDTH-1:0] cfg_mask,
    input  logic [CH_WIDTH-1:0] cfg_value,
    input  logic [CH_WIDTH-1:0] cfg_edge,
    input  logic [AW-1:0]       cfg_pre,
    input  logic [AW-1:0]       cfg_post,
    output logic [2:0]          o_state,
    output logic                o_triggered,
    output logic                o_done,
    output logic [CH_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready
);

    la_state_e           state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       pre_q, pre_d;
    logic [AW-1:0]       post_q, post_d;
    logic [AW:0]         rd_left_q, rd_left_d;
    logic [CH_WIDTH-1:0] mask_q, mask_d;
    logic [CH_WIDTH-1:0] value_q, value_d;
    logic [CH_WIDTH-1:0] edge_q, edge_d;
    logic                triggered_q, triggered_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;
    logic [CH_WIDTH-1:0] rd_data_q;

    logic                wr_en, rd_en, restart, strobe;
    logic                pat_hit, trig_hit;
    logic [AW-1:0]       post_eff;
    logic [AW+1:0]       win_sum;
    logic [CH_WIDTH-1:0] buf_mem [DEPTH];

    assign strobe = i_sample_en &&
                    (state_q == PRE || state_q == WAIT || state_q == POST);

    la_trigger_match #(.CH_WIDTH(CH_WIDTH)) u_match (
        .i_clk     (i_clk),
        ._mrst     (_mrst),
        .i_data    (i_data),
        .i_strobe  (strobe),
        .i_restart (restart),
        .cfg_mask  (mask_q),
        .cfg_value (value_q),
        .cfg_edge  (edge_q),
        .o_match   (pat_hit)
    );

`ifdef LA_EXT_TRIG_EN
    logic ext_q, ext_d, ext_prev_q, ext_prev_d;

    assign ext_d      = i_ext_trig;
    assign ext_prev_d = ext_q;

    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            ext_q      <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            ext_prev_q <= ext_prev_d;
        end
    end

    assign trig_hit = pat_hit | (ext_q & ~ext_prev_q);
`else
    assign trig_hit = pat_hit;
`endif

    // The frame must fit the buffer, so an oversized post window is shortened.
    always_comb begin
        win_sum  = {2'b00, cfg_pre} + {2'b00, cfg_post} + (AW+2)'(1);
        post_eff = cfg_post;
        if (win_sum > (AW+2)'(DEPTH)) begin
            post_eff = AW'(DEPTH - 1) - cfg_pre;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        rd_left_d   = rd_left_q;
        mask_d      = mask_q;
        value_d     = value_q;
        edge_d      = edge_q;
        triggered_d = triggered_q;
        done_d      = 1'b0;
        rd_valid_d  = rd_valid_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        restart     = 1'b0;

        if (i_abort) begin
            state_d     = IDLE;
            triggered_d = 1'b0;
            rd_valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_arm) begin
                        mask_d    = cfg_mask;
                        value_d   = cfg_value;
                        edge_d    = cfg_edge;
                        pre_d     = cfg_pre;
                        post_d    = post_eff;
                        rd_left_d = (AW+1)'(cfg_pre) + (AW+1)'(post_eff) + (AW+1)'(1);
                        wr_ptr_d  = '0;
                        cnt_d     = '0;
                        restart   = 1'b1;
                        state_d   = PRE;
                    end
                end
                PRE: begin
                    if (pre_q == '0) begin
                        state_d = WAIT;
                    end else if (i_sample_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + AW'(1);
                        if (cnt_q == pre_q - AW'(1)) begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_sample_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (trig_hit) begin
                            // Readout starts pre_q slots before the trigger slot.
                            rd_ptr_d    = wr_ptr_q - pre_q;
                            triggered_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = (post_q == '0) ? READOUT : POST;
                        end
                    end
                end
                POST: begin
                    if (i_sample_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + AW'(1);
                        if (cnt_q == post_q - AW'(1)) begin
                            state_d = READOUT;
                        end
                    end
                end
                READOUT: begin
                    rd_en = 1'b1;
                    if (!rd_valid_q) begin
                        rd_valid_d = 1'b1;
                    end else if (rd_ready) begin
                        if (rd_left_q == (AW+1)'(1)) begin
                            rd_en       = 1'b0;
                            rd_valid_d  = 1'b0;
                            done_d      = 1'b1;
                            triggered_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            rd_ptr_d  = rd_ptr_q + AW'(1);
                            rd_left_d = rd_left_q - (AW+1)'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            rd_left_q   <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            edge_q      <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            rd_left_q   <= rd_left_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            edge_q      <= edge_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q] <= i_data;
        end
    end

    // Re-reading the held address during a stall keeps rd_data stable.
    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= buf_mem[rd_ptr_d];
        end
    end

    assign o_state     = state_q;
    assign o_triggered = triggered_q;
    assign o_done      = done_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at CH_WIDTH=8, DEPTH=16 with hand-computed frames.
// Define LA_EXT_TRIG_EN to also exercise the external trigger input.
module tb_la_capture_core;

    localparam int CH_WIDTH = 8;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_POST    = 3'd3;
    localparam logic [2:0] ST_READOUT = 3'd4;

    logic                i_clk = 1'b0;
    logic                _mrst;
    logic [CH_WIDTH-1:0] i_data;
    logic                i_sample_en;
    logic                i_arm;
    logic                i_abort;
    logic [CH_WIDTH-1:0] cfg_mask, cfg_value, cfg_edge;
    logic [AW-1:0]       cfg_pre, cfg_post;
    logic [2:0]          o_state;
    logic                o_triggered;
    logic                o_done;
    logic [CH_WIDTH-1:0] rd_data;
    logic                rd_valid;
    logic                rd_ready;
`ifdef LA_EXT_TRIG_EN
    logic                i_ext_trig;
    int                  ext_at_idx;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 i_clk = ~i_clk;

    la_capture_core #(.CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        ._mrst       (_mrst),
        .i_data      (i_data),
        .i_sample_en (i_sample_en),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
`ifdef LA_EXT_TRIG_EN
        .i_ext_trig  (i_ext_trig),
`endif
        .cfg_mask    (cfg_mask),
        .cfg_value   (cfg_value),
        .cfg_edge    (cfg_edge),
        .cfg_pre     (cfg_pre),
        .cfg_post    (cfg_post),
        .o_state     (o_state),
        .o_triggered (o_triggered),
        .o_done      (o_done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic strobe);
        i_data      = data;
        i_sample_en = strobe;
        tick();
    endtask

    task automatic build_ramp(input int n);
        stim_q.delete();
        for (int k = 0; k < n; k++) stim_q.push_back(8'(k));
    endtask

    task automatic arm(input logic [3:0] pre, input logic [3:0] post, input logic [7:0] mask,
                       input logic [7:0] value, input logic [7:0] edge_bits);
        cfg_pre   = pre;
        cfg_post  = post;
        cfg_mask  = mask;
        cfg_value = value;
        cfg_edge  = edge_bits;
        i_arm     = 1'b1;
        applyStimulus(stim_q[0], 1'b1);
        i_arm     = 1'b0;
        // scramble cfg after arming; a core that does not latch would misbehave
        cfg_pre   = 4'd0;
        cfg_post  = 4'd0;
        cfg_mask  = 8'h00;
        cfg_value = 8'h00;
        cfg_edge  = 8'h00;
    endtask

    task automatic capture_frame(input string name, input logic [3:0] pre, input logic [3:0] post,
                                 input logic [7:0] mask, input logic [7:0] value,
                                 input logic [7:0] edge_bits, input int stall_at);
        int idx, guard, lat, dones, stall_left;
        bit stall_done;
        got_q.delete();
        rd_ready = 1'b1;
        arm(pre, post, mask, value, edge_bits);
        idx   = 1;
        guard = 0;
        while (o_state != ST_READOUT && guard < 200) begin
`ifdef LA_EXT_TRIG_EN
            if (ext_at_idx >= 0 && idx >= ext_at_idx) i_ext_trig = 1'b1;
`endif
            applyStimulus((idx < stim_q.size()) ? stim_q[idx] : 8'h00, 1'b1);
            idx++;
            guard++;
        end
        checkOutput({name, " reach readout"}, 32'(guard < 200), 32'd1);
        checkOutput({name, " triggered"}, 32'(o_triggered), 32'd1);

        lat = 0;
        while (!rd_valid && lat < 4) begin
            applyStimulus(8'h00, 1'b1);
            lat++;
        end
        checkOutput({name, " valid latency ok"}, 32'(lat <= 2), 32'd1);

        guard      = 0;
        dones      = 0;
        stall_left = 0;
        stall_done = 1'b0;
        while (o_state == ST_READOUT && guard < 100) begin
            if (!stall_done && got_q.size() == stall_at) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            rd_ready = (stall_left == 0);
            if (stall_left > 0) begin
                applyStimulus(8'h00, 1'b1);
                stall_left--;
                checkOutput({name, " stall data"}, 32'(rd_data), 32'(exp_q[stall_at]));
                checkOutput({name, " stall valid"}, 32'(rd_valid), 32'd1);
            end else begin
                if (rd_valid) got_q.push_back(rd_data);
                applyStimulus(8'h00, 1'b1);
            end
            if (o_done) dones++;
            guard++;
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h00, 1'b1);
            if (o_done) dones++;
        end
        checkOutput({name, " done pulses"}, 32'(dones), 32'd1);
        checkOutput({name, " idle after"}, 32'(o_state), 32'(ST_IDLE));
        checkOutput({name, " triggered clr"}, 32'(o_triggered), 32'd0);
        checkOutput({name, " frame length"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            checkOutput($sformatf("%s word%0d", name, k),
                        32'((k < got_q.size()) ? got_q[k] : 8'hxx), 32'(exp_q[k]));
        end
    endtask

    initial begin
        int guard, seen_valid;
        _mrst       = 1'b0;
        i_data      = 8'h00;
        i_sample_en = 1'b0;
        i_arm       = 1'b0;
        i_abort     = 1'b0;
        rd_ready    = 1'b1;
        cfg_mask    = 8'h00;
        cfg_value   = 8'h00;
        cfg_edge    = 8'h00;
        cfg_pre     = 4'd0;
        cfg_post    = 4'd0;
`ifdef LA_EXT_TRIG_EN
        i_ext_trig  = 1'b0;
        ext_at_idx  = -1;
`endif
        tick();
        tick();
        checkOutput("reset state", 32'(o_state), 32'(ST_IDLE));
        checkOutput("reset triggered", 32'(o_triggered), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset rd_data", 32'(rd_data), 32'd0);
        _mrst = 1'b1;
        tick();

        // pattern trigger on 0A, pre 3 / post 4
        build_ramp(60);
        exp_q = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
        capture_frame("ramp", 4'd3, 4'd4, 8'hFF, 8'h0A, 8'h00, -1);

        // same frame, 3-cycle stall with word 3 on the bus
        capture_frame("stall", 4'd3, 4'd4, 8'hFF, 8'h0A, 8'h00, 3);

        // bit0 edge: high through arm, falls at 08, rises at 0B
        stim_q = '{8'h01, 8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0D, 8'h0F};
        exp_q  = '{8'h08, 8'h0A, 8'h0B, 8'h0D, 8'h0F};
        capture_frame("edge", 4'd2, 4'd2, 8'h00, 8'h00, 8'h01, -1);

        // buffer wraps before the trigger at 40
        build_ramp(80);
        exp_q = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A};
        capture_frame("wrap", 4'd5, 4'd2, 8'hFF, 8'h28, 8'h00, -1);

        // pre 10 + post 10 clamps to a 16-word frame ending at 25
        build_ramp(80);
        exp_q.delete();
        for (int k = 10; k <= 25; k++) exp_q.push_back(8'(k));
        capture_frame("clamp", 4'd10, 4'd10, 8'hFF, 8'h14, 8'h00, -1);

        // abort during POST
        build_ramp(60);
        arm(4'd2, 4'd6, 8'hFF, 8'h05, 8'h00);
        guard      = 1;
        seen_valid = 0;
        while (o_state != ST_POST && guard < 100) begin
            applyStimulus(stim_q[guard], 1'b1);
            guard++;
        end
        checkOutput("abort reach post", 32'(o_state), 32'(ST_POST));
        i_abort = 1'b1;
        applyStimulus(8'h00, 1'b1);
        i_abort = 1'b0;
        checkOutput("abort state", 32'(o_state), 32'(ST_IDLE));
        checkOutput("abort triggered", 32'(o_triggered), 32'd0);
        checkOutput("abort rd_valid", 32'(rd_valid), 32'd0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(8'h05, 1'b1);
            if (rd_valid || o_done) seen_valid++;
        end
        checkOutput("abort quiet", 32'(seen_valid), 32'd0);
        checkOutput("abort stays idle", 32'(o_state), 32'(ST_IDLE));

`ifdef LA_EXT_TRIG_EN
        // pattern never matches; i_ext_trig rises alongside sample 9, registered edge meets sample 10
        build_ramp(60);
        ext_at_idx = 9;
        exp_q = '{8'h08, 8'h09, 8'h0A, 8'h0B};
        capture_frame("ext", 4'd2, 4'd1, 8'hFF, 8'hFF, 8'h00, -1);
        i_ext_trig = 1'b0;
        ext_at_idx = -1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
Parametrised successor to the single-channel capture path. It samples a CH_WIDTH-bit input bus into a circular on-chip buffer while armed. It fires on a masked pattern/edge trigger, retains a programmable number of pre-trigger samples, then captures post-trigger samples. It then streams the frame out over a valid/ready port, oldest sample first. It sits between the input synchroniser/prescaler and the host-readout FIFO.

Parameters:
CH_WIDTH, 8, sampled channels per word
DEPTH, 256, buffer words (power of 2, >=4); AW = $clog2(DEPTH)

Ports:
i_clk  in  1  sole clock
_mrst  in  1  synchronous active-low reset
i_data  in  CH_WIDTH  sampled bus (already synchronised)
i_sample_en  in  1  prescaler strobe; one sample taken per high cycle
i_arm  in  1  start pulse, honoured only in IDLE
i_abort  in  1  return to IDLE from any state, frame discarded
cfg_mask  in  CH_WIDTH  bits compared against cfg_value
cfg_value  in  CH_WIDTH  level pattern
cfg_edge  in  CH_WIDTH  bits that must see a 0->1 edge
cfg_pre  in  AW  pre-trigger samples
cfg_post  in  AW  post-trigger samples (excluding trigger sample)
o_state  out  3  current FSM state encoding
o_triggered  out  1  high from trigger sample until IDLE
o_done  out  1  one-cycle pulse when READOUT ends
rd_data  out  CH_WIDTH  readout word
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts when rd_valid & rd_ready

Behaviour:
- Reset (_mrst=0 at posedge): state IDLE. o_triggered=0, o_done=0, rd_valid=0, rd_data=0, pointers and counters 0. The buffer RAM is not cleared.
- cfg_* are latched on the accepted i_arm. Changes afterwards have no effect until the next arm.
- Clamp at latch: if cfg_pre+cfg_post+1 > DEPTH, post_eff = DEPTH-1-cfg_pre.
- States: IDLE -> PRE -> WAIT -> POST -> READOUT -> IDLE.
- IDLE: i_arm -> PRE with wr_ptr=0. prev_data is loaded with the first sample, so no false edge fires.
- PRE: every strobe writes i_data at wr_ptr, then wr_ptr++. After cfg_pre writes -> WAIT. With cfg_pre=0, go straight to WAIT on the next cycle.
- WAIT: every strobe writes the sample (wr_ptr wraps mod DEPTH) and evaluates the trigger on that same sample.
- Trigger condition: ((i_data ^ cfg_value) & cfg_mask)==0 AND (cfg_edge & ~prev_data & i_data)==cfg_edge.
- With mask=edge=0, the first WAIT sample triggers.
- On trigger: trig_ptr=wr_ptr (the slot just written), o_triggered=1, -> POST. With post_eff=0, go -> READOUT directly.
- POST: the next post_eff strobed samples are written; then -> READOUT.
- READOUT: start = trig_ptr - cfg_pre (mod DEPTH); length = cfg_pre+1+post_eff words.
- Readout timing: synchronous RAM read, 1-cycle latency. rd_valid asserts no later than 2 cycles after READOUT entry.
- rd_data/rd_valid are registered and held stable while rd_valid & ~rd_ready. Back-to-back transfers sustain 1 word/cycle.
- After the last word is accepted: rd_valid=0, o_done pulses 1 cycle, o_triggered=0, -> IDLE.
- i_sample_en is ignored in IDLE and READOUT.
- Simultaneous events: i_abort beats all other inputs. An abort in READOUT drops rd_valid on the next cycle. i_arm outside IDLE is ignored.
- prev_data updates on every strobe in PRE/WAIT/POST.

Optional Feature:
LA_EXT_TRIG_EN:
- Defined: adds input i_ext_trig (1 bit, synchronous). A 0->1 edge of i_ext_trig (registered) coinciding with a strobe in WAIT also triggers, ORed with the pattern trigger.
- Undefined: port absent; only the pattern/edge trigger exists.

Decomposition:
- Package la_pkg holds:
  - state enum IDLE=0, PRE=1, WAIT=2, POST=3, READOUT=4 (3 bits)
  - localparam function for AW
- Sub-module la_trigger_match: combinational pattern/edge compare plus the prev_data register. Reusable for future multi-group triggers.
- The buffer is an inferred simple dual-port RAM inside la_capture_core.

Test Plan:
- CH_WIDTH=8, DEPTH=16. Ramp 0,1,2… on every strobe, arm with pre=3, post=4, mask=FF, value=0A. Required: readout 07,08,09,0A,0B,0C,0D,0E; o_done once.
- Edge trigger: cfg_edge=01, mask=00, bit0 held high through arm. Required: no trigger until bit0 falls and rises again; the trigger word is the first with bit0=1 after the low.
- Wrap: pre=5 with trigger after 40 samples (buffer wrapped). Required: the 5 pre words are the 5 samples immediately before the trigger, in order.
- Backpressure: hold rd_ready=0 for 3 cycles mid-frame. Required: rd_data is unchanged during the stall and no word is lost or duplicated (full 8-word frame matches).
- Clamp and abort: pre=10, post=10 at DEPTH=16 gives a 16-word frame. Separately, i_abort during POST gives IDLE next cycle with o_triggered=0 and rd_valid never asserted.
- With LA_EXT_TRIG_EN, mask=FF, value never matched, pulse i_ext_trig. Required: the trigger lands on the strobe coinciding with the registered edge.
